// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant (drives onehot_mux sel); 1-cycle request-to-grant latency.
// Backpressure: grant/ptr frozen while out_valid & !out_ready; optional packet lock holds grant until last beat.
module onehot_rr_arbiter #(
  parameter int N           = 4,
  parameter bit LOCK_PACKET = 1'b1,
  parameter int IW          = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  req_last,
  output logic [N-1:0]  req_ready,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt, ptr_adv;
  logic [N-1:0]  grant_nxt;
  logic [IW-1:0] idx_nxt;
  logic [IW-1:0] win;
  logic          end_beat;

  // First requester at or after p, wrapping; scanned high-to-low so the lowest offset wins.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    int            idx;
    w = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % N;
      if (r[idx]) w = IW'(idx);
    end
    return w;
  endfunction

  assign req_ready = grant & {N{out_ready}};
  assign out_valid = |(req & grant);
  assign out_last  = LOCK_PACKET ? |(req_last & grant) : out_valid;
  assign end_beat  = out_valid & out_ready & (LOCK_PACKET ? out_last : 1'b1);
  assign ptr_adv   = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
  assign win       = pick(req, (state == BUSY) ? ptr_adv : ptr);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    idx_nxt   = grant_idx;
    if (state == IDLE) begin
      if (|req) begin
        state_nxt = BUSY;
        grant_nxt = N'(1) << win;
        idx_nxt   = win;
      end
    end else if (end_beat) begin
      ptr_nxt = ptr_adv;
      if (|req) begin
        grant_nxt = N'(1) << win;
        idx_nxt   = win;
      end else begin
        state_nxt = IDLE;
        grant_nxt = '0;
        idx_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant     <= grant_nxt;
      grant_idx <= idx_nxt;
    end
  end

  grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));

endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- Round-robin arbiter that produces a registered one-hot grant, which drives the `sel` input of the downstream `onehot_mux` data-path stage.
- Arbitrates N valid/ready requesters onto one shared output channel.
- Optionally holds the grant for the full length of a multi-beat packet, delimited by a per-requester `last` flag.
- Grant is stable between handshakes, so the mux output is stable while stalled.

Parameters:
- N, 4: number of requesters; legal values are N >= 2.
- LOCK_PACKET, 1: if 1, the grant is held until a beat with `last` is accepted; if 0, every accepted beat ends the grant (the `last` inputs are ignored).
- IW, $clog2(N): width of `grant_idx` (derived; do not override).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester valid.
- req_last  input  N  per-requester end-of-packet flag; qualified by `req`.
- req_ready  output  N  per-requester ready; equals `grant & {N{out_ready}}`.
- grant  output  N  registered one-hot grant (all-zero when idle); drives the mux `sel`.
- grant_idx  output  IW  binary index of `grant`; 0 when idle.
- out_valid  output  1  equals `|(req & grant)`.
- out_last  output  1  equals `|(req_last & grant)` when LOCK_PACKET=1; equals `out_valid` when LOCK_PACKET=0.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (synchronous, dominant over all other activity, including mid-packet):
  - state=IDLE, grant=0, grant_idx=0, ptr=0.
  - Therefore req_ready=0, out_valid=0, out_last=0.
- State machine, two states: IDLE and BUSY. `ptr` is the index with highest priority.
- Arbitration function `pick(req, ptr)`: the first index k in the order ptr, ptr+1, …, N-1, 0, …, ptr-1 with req[k]=1.
- IDLE:
  - If `|req`: the next cycle has grant=onehot(pick(req, ptr)) and state=BUSY.
  - Otherwise remain in IDLE.
  - Arbitration latency is one cycle from req rising to grant.
- BUSY:
  - grant holds until an end-of-grant beat: `out_valid & out_ready & end`, where end = `out_last` (LOCK_PACKET=1) or 1 (LOCK_PACKET=0).
- On an end-of-grant beat:
  - ptr <= (grant_idx+1) mod N, with wrap from N-1 to 0.
  - Re-arbitrate in the same cycle, using the updated ptr and the current `req` with the just-finished requester's bit included.
  - If any request exists: the next cycle's grant is the winner and state stays BUSY (back-to-back, no bubble).
  - Otherwise: grant=0 and state=IDLE.
- A non-last accepted beat changes nothing: grant and ptr hold.
- Stall: while `out_valid & !out_ready`, grant, grant_idx and ptr are unchanged.
- Granted requester drops `req` mid-packet: this is a protocol violation. Grant is still held and `out_valid` goes low. There is no timeout.
- Non-granted requesters: their `req_ready` is always 0.
- grant is never multi-hot. An assertion checks `$onehot0(grant)`.
- ptr only advances on an end-of-grant beat, never in IDLE.
- Fairness: with all N requesting single-beat packets continuously, grants rotate 0,1,…,N-1,0 with one grant per accepted beat.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles → grant=0, out_valid=0, req_ready=0, grant_idx=0 throughout.
- From reset with LOCK_PACKET=0: assert req=4'b1111 with all `last`=1 and out_ready=1 → the cycle after req rises shows grant=0001, then 0010, 0100, 1000, 0001 on consecutive cycles with no bubble.
- LOCK_PACKET=1, req=4'b0101: requester 0 sends a 3-beat packet (`last` on beat 3) → grant=0001 for all 3 beats, then grant=0100 on the next cycle, ptr=1 after packet 0 ends.
- Stall: granted requester 2 mid-packet, out_ready=0 for 4 cycles while req[1] is asserted → grant stays 0100, grant_idx=2, req_ready=0000; accepts resume when out_ready=1.
- Wrap: ptr=3, req=4'b1001, single-beat → grant=1000, then 0001; ptr goes 0, then 1.
- Assert rst mid-packet with grant=0010 → the next cycle shows grant=0, state=IDLE, ptr=0; with req=4'b0010 still high, grant=0010 again one cycle after rst deasserts.
